trdb_retire_serializer: RTL
===========================

TRDB_RETIRE_SERIALIZER -- requirements
Module: trdb_retire_serializer

Interface
REQ-001 SHALL have parameter NRET, default 2, number of retirement lanes per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, number of buffer entries; power of two and at least 2*NRET.
REQ-003 SHALL have parameter CNTW, default 16, width of the drop counter.
REQ-004 SHALL take XLEN, ILEN, CAUSELEN and PRIVLEN from trdb_pkg.
REQ-005 Ports SHALL be as follows (one clock; reset is asynchronous and active-low).
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- test_mode_i  in  1  test mode; no functional effect.
- flush_i  in  1  synchronous buffer clear.
- ivalid_i  in  NRET  lane retired.
- iexception_i  in  NRET  lane excepted.
- interrupt_i  in  NRET  exception is an interrupt.
- cause_i  in  NRET x CAUSELEN  cause.
- tval_i  in  NRET x XLEN  trap value.
- priv_i  in  NRET x PRIVLEN  privilege.
- iaddr_i  in  NRET x XLEN  PC.
- instr_i  in  NRET x ILEN  instruction.
- compressed_i  in  NRET  compressed flag.
- stall_o  out  1  upstream must hold retirement.
- out_valid_o  out  1  entry available.
- out_ready_i  in  1  consumer accepts entry.
- out_*_o  out  per-field widths  one lane's fields (exception, interrupt, cause, tval, priv, iaddr, instr, compressed).
- occupancy_o  out  $clog2(DEPTH+1)  entries held.
- overflow_o  out  1  sticky drop flag.
- dropped_cnt_o  out  CNTW  saturating count of dropped lanes.

Function
REQ-006 SHALL buffer retirements in a circular FIFO of DEPTH entries, with read and write pointers that wrap modulo DEPTH.
REQ-007 A lane k SHALL be eligible when ivalid_i[k]=1 and no lane j<k has ivalid_i[j]=1 and iexception_i[j]=1 in the same cycle; lanes after the first excepting lane SHALL be discarded and not counted as drops.
REQ-008 Eligible lanes SHALL be written in ascending lane order into consecutive entries, gaps removed; all writes of one cycle are visible to the read side the next cycle.
REQ-009 stall_o SHALL be combinational from the registered count: stall_o = 1 when DEPTH-count < NRET.
REQ-010 When stall_o=1, all eligible lanes of that cycle SHALL be dropped (none written); the drop counter increases by the eligible lane count, saturating at 2^CNTW-1; overflow_o sets to 1.
REQ-011 out_valid_o SHALL equal (count != 0); out_*_o SHALL show the head entry combinationally from storage.
REQ-012 A pop SHALL occur when out_valid_o and out_ready_i are both 1; the head fields SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-013 Simultaneous push and pop SHALL update the count as count + pushed - popped in one cycle; the count SHALL never exceed DEPTH and never go below 0.
REQ-014 A pop from the last entry while lanes push in the same cycle SHALL leave out_valid_o=1 the next cycle, with no bubble.
REQ-015 When flush_i=1, the pointers and count SHALL clear, overflow_o and dropped_cnt_o SHALL clear, and that cycle's inputs and pop SHALL be ignored; flush SHALL have priority over all other events.
REQ-016 occupancy_o SHALL equal the registered count.
REQ-017 Minimum latency from input to out_valid_o SHALL be 1 cycle; throughput SHALL be 1 pop per cycle.

Reset
REQ-018 While rst_ni=0, the pointers, count, overflow_o and dropped_cnt_o SHALL be 0, and out_valid_o, stall_o and occupancy_o SHALL be 0.
REQ-019 Reset asserted mid-operation SHALL discard all buffered entries immediately; storage contents need no reset.

Verification
REQ-020 NRET=2, DEPTH=8: lanes 0 and 1 valid with iaddr 0x100 and 0x104, out_ready_i=1 -> 0x100 out the next cycle, 0x104 the cycle after, occupancy_o returns to 0.
REQ-021 ivalid_i=2'b11 with iexception_i[0]=1 -> one entry (lane 0, exception=1) written, lane 1 discarded, dropped_cnt_o stays 0.
REQ-022 out_ready_i=0, two lanes per cycle for 3 cycles -> occupancy_o=6 and stall_o=0; 4th cycle -> occupancy_o=8, stall_o=1; lanes then presented -> dropped_cnt_o=2, overflow_o=1, occupancy_o stays 8.
REQ-023 FIFO full with write pointer wrapped, then out_ready_i=1 for 8 cycles -> entries exit in original order, out_valid_o falls after the 8th pop.
REQ-024 flush_i=1 with occupancy_o=5, dropped_cnt_o=3, and valid lanes present -> next cycle occupancy_o=0, out_valid_o=0, dropped_cnt_o=0, overflow_o=0.
REQ-025 rst_ni pulled low with occupancy_o=4 -> all outputs read 0 during reset; after release, out_valid_o=0 until the next push.

Source files
------------

// File: rtl/trdb_retire_serializer.sv
// Retirement serializer: compacts up to NRET retiring lanes per cycle into a circular FIFO, one entry out per cycle.
// Pushes are visible on the output one cycle later; when fewer than NRET slots are free the whole cycle's lanes are dropped and counted.
package trdb_pkg;
  localparam int XLEN     = 32;
  localparam int ILEN     = 32;
  localparam int CAUSELEN = 5;
  localparam int PRIVLEN  = 2;
endpackage

module trdb_retire_serializer
  import trdb_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        test_mode_i,
  input  logic                        flush_i,
  input  logic [NRET-1:0]             ivalid_i,
  input  logic [NRET-1:0]             iexception_i,
  input  logic [NRET-1:0]             interrupt_i,
  input  logic [NRET*CAUSELEN-1:0]    cause_i,
  input  logic [NRET*XLEN-1:0]        tval_i,
  input  logic [NRET*PRIVLEN-1:0]     priv_i,
  input  logic [NRET*XLEN-1:0]        iaddr_i,
  input  logic [NRET*ILEN-1:0]        instr_i,
  input  logic [NRET-1:0]             compressed_i,
  output logic                        stall_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        out_exception_o,
  output logic                        out_interrupt_o,
  output logic [CAUSELEN-1:0]         out_cause_o,
  output logic [XLEN-1:0]             out_tval_o,
  output logic [PRIVLEN-1:0]          out_priv_o,
  output logic [XLEN-1:0]             out_iaddr_o,
  output logic [ILEN-1:0]             out_instr_o,
  output logic                        out_compressed_o,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy_o,
  output logic                        overflow_o,
  output logic [CNTW-1:0]             dropped_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = $clog2(NRET+1);

  typedef struct packed {
    logic                exc;
    logic                intr;
    logic [CAUSELEN-1:0] cause;
    logic [XLEN-1:0]     tval;
    logic [PRIVLEN-1:0]  priv;
    logic [XLEN-1:0]     iaddr;
    logic [ILEN-1:0]     instr;
    logic                cmp;
  } ent_t;

  ent_t            mem_q [DEPTH];
  ent_t            lane_ent [NRET];
  logic [PW-1:0]   slot [NRET];
  logic [NRET-1:0] elig;
  logic [LW-1:0]   n_elig;
  logic            blocked;

  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [CNTW-1:0] drop_q, drop_d;
  logic [CNTW:0]   drop_sum;
  logic            push, pop;
  logic            unused_test_mode;

  assign unused_test_mode = test_mode_i;

  // Lanes behind the first excepting lane never retire; eligible lanes are packed into consecutive slots.
  always_comb begin
    blocked = 1'b0;
    n_elig  = '0;
    for (int k = 0; k < NRET; k++) begin
      elig[k] = 1'b0;
      slot[k] = PW'(n_elig);
      lane_ent[k] = '{exc:   iexception_i[k],
                      intr:  interrupt_i[k],
                      cause: cause_i[k*CAUSELEN +: CAUSELEN],
                      tval:  tval_i[k*XLEN +: XLEN],
                      priv:  priv_i[k*PRIVLEN +: PRIVLEN],
                      iaddr: iaddr_i[k*XLEN +: XLEN],
                      instr: instr_i[k*ILEN +: ILEN],
                      cmp:   compressed_i[k]};
      if (ivalid_i[k] && !blocked) begin
        elig[k] = 1'b1;
        n_elig  = n_elig + LW'(1);
      end
      if (ivalid_i[k] && iexception_i[k]) blocked = 1'b1;
    end
  end

  assign stall_o     = (CW'(DEPTH) - count_q) < CW'(NRET);
  assign out_valid_o = (count_q != '0);
  assign occupancy_o = count_q;
  assign overflow_o  = ovf_q;
  assign dropped_cnt_o = drop_q;

  assign push = !stall_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  assign drop_sum = {1'b0, drop_q} + (CNTW+1)'(n_elig);

  always_comb begin
    wptr_d  = wptr_q + (push ? PW'(n_elig) : '0);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + (push ? CW'(n_elig) : '0) - CW'(pop);
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (stall_o && (n_elig != '0)) begin
      ovf_d  = 1'b1;
      drop_d = drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
    end
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is not reset; the cleared count alone hides stale entries.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NRET; k++) begin
      if (push && elig[k]) mem_q[wptr_q + slot[k]] <= lane_ent[k];
    end
  end

  assign out_exception_o  = mem_q[rptr_q].exc;
  assign out_interrupt_o  = mem_q[rptr_q].intr;
  assign out_cause_o      = mem_q[rptr_q].cause;
  assign out_tval_o       = mem_q[rptr_q].tval;
  assign out_priv_o       = mem_q[rptr_q].priv;
  assign out_iaddr_o      = mem_q[rptr_q].iaddr;
  assign out_instr_o      = mem_q[rptr_q].instr;
  assign out_compressed_o = mem_q[rptr_q].cmp;

endmodule
